// File: rtl/adc_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : adc_conv_arbiter
// Purpose  : Shares one SAR ADC core among NREQ requesters. It picks a pending
//            request, drives the channel mux, waits a settle time, and then
//            holds a level SoC. It captures the result on the rising edge of
//            EoC and returns it with a one-cycle done pulse. A programmable
//            timeout abandons a conversion that never completes.
// Ports    : clk, rst            clock, asynchronous active-high reset
//            en, prio_mode       grant enable; 0 = round-robin, 1 = fixed prio
//            req, req_ch         level requests and per-requester channels
//            settle, gap         mux settle cycles, minimum SoC-low cycles
//            timeout_limit       EoC wait limit in cycles (0 = no timeout)
//            gnt, ch_sel, soc    one-hot grant, ADC mux channel, start of conv
//            eoc, adc_data       ADC end of conversion (level) and result
//            done, rdata         per-requester done pulse, last captured result
//            timeout, busy       timeout pulse, arbiter not idle
// Revision : 1.0 - initial release
// ============================================================================
module adc_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int CH_W = 3,
  parameter int DW   = 10,
  parameter int TO_W = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   prio_mode,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*CH_W-1:0]   req_ch,
  input  logic [3:0]             settle,
  input  logic [7:0]             gap,
  input  logic [TO_W-1:0]        timeout_limit,
  output logic [NREQ-1:0]        gnt,
  output logic [CH_W-1:0]        ch_sel,
  output logic                   soc,
  input  logic                   eoc,
  input  logic [DW-1:0]          adc_data,
  output logic [NREQ-1:0]        done,
  output logic [DW-1:0]          rdata,
  output logic                   timeout,
  output logic                   busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CONV   = 3'd2,
    S_DONE   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

  state_t            state, state_next;
  logic [PW-1:0]     ptr, ptr_next, winner;
  logic [3:0]        settle_cnt, settle_cnt_next;
  logic [TO_W-1:0]   to_cnt, to_cnt_next, to_cnt_inc;
  logic [7:0]        hold_cnt, hold_cnt_next, hold_load;
  logic [NREQ-1:0]   gnt_next, done_next;
  logic [CH_W-1:0]   ch_sel_next;
  logic [DW-1:0]     rdata_next;
  logic              soc_next, timeout_next;
  logic              eoc_q, eoc_rise, limit_hit;
  logic [CH_W-1:0]   ch_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ch_slice
      assign ch_arr[gi] = req_ch[gi*CH_W +: CH_W];
    end
  endgenerate

  // Search NREQ positions starting at 'start', wrapping. Iterating from the
  // far end downward lets the nearest asserted position overwrite the result.
  always_comb begin
    int start;
    logic [PW-1:0] idx;
    winner = '0;
    idx    = '0;
    start  = prio_mode ? 0 : int'(ptr) + 1;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((start + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

  assign to_cnt_inc = to_cnt + TO_W'(1);
  assign eoc_rise   = eoc & ~eoc_q;
  assign limit_hit  = (timeout_limit != '0) && (to_cnt_inc == timeout_limit);
  // HOLD lasts max(gap,1) cycles; the counter holds remaining-minus-one.
  assign hold_load  = (gap == 8'd0) ? 8'd0 : gap - 8'd1;
  assign busy       = (state != S_IDLE);

  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    gnt_next        = gnt;
    ch_sel_next     = ch_sel;
    rdata_next      = rdata;
    settle_cnt_next = settle_cnt;
    hold_cnt_next   = hold_cnt;
    to_cnt_next     = '0;
    soc_next        = 1'b0;
    done_next       = '0;
    timeout_next    = 1'b0;

    case (state)
      S_IDLE: begin
        if (en && (req != '0)) begin
          state_next      = S_SETTLE;
          gnt_next        = NREQ'(1) << winner;
          ch_sel_next     = ch_arr[winner];
          ptr_next        = winner;
          settle_cnt_next = settle;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_next = S_CONV;
        end else begin
          settle_cnt_next = settle_cnt - 4'd1;
        end
      end

      S_CONV: begin
        to_cnt_next = to_cnt_inc;
        // The edge is tested first so a simultaneous limit match loses.
        if (eoc_rise) begin
          rdata_next = adc_data;
          done_next  = gnt;
          state_next = S_DONE;
        end else if (limit_hit) begin
          timeout_next  = 1'b1;
          gnt_next      = '0;
          hold_cnt_next = hold_load;
          state_next    = S_HOLD;
        end else begin
          soc_next = 1'b1;
        end
      end

      S_DONE: begin
        gnt_next      = '0;
        hold_cnt_next = hold_load;
        state_next    = S_HOLD;
      end

      S_HOLD: begin
        if (hold_cnt == 8'd0) begin
          state_next = S_IDLE;
        end else begin
          hold_cnt_next = hold_cnt - 8'd1;
        end
      end

      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      ptr        <= PW'(NREQ - 1);
      gnt        <= '0;
      ch_sel     <= '0;
      soc        <= 1'b0;
      done       <= '0;
      rdata      <= '0;
      timeout    <= 1'b0;
      eoc_q      <= 1'b0;
      settle_cnt <= 4'd0;
      hold_cnt   <= 8'd0;
      to_cnt     <= '0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      gnt        <= gnt_next;
      ch_sel     <= ch_sel_next;
      soc        <= soc_next;
      done       <= done_next;
      rdata      <= rdata_next;
      timeout    <= timeout_next;
      eoc_q      <= eoc;
      settle_cnt <= settle_cnt_next;
      hold_cnt   <= hold_cnt_next;
      to_cnt     <= to_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_conv_arbiter
// Purpose  : Self-checking bench for adc_conv_arbiter. A timestamp-based
//            transaction model predicts every output each cycle. Directed
//            scenarios pin the model with literal expectations, and a random
//            phase exercises arbitration, settle, gap and timeout settings.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_conv_arbiter;

  localparam int NREQ = 4;
  localparam int CH_W = 3;
  localparam int DW   = 10;
  localparam int TO_W = 12;
  localparam longint BIG = 64'h3fff_ffff_ffff_ffff;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic                 prio_mode = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*CH_W-1:0] req_ch = '0;
  logic [3:0]           settle = 4'd2;
  logic [7:0]           gap = 8'd3;
  logic [TO_W-1:0]      timeout_limit = '0;
  logic                 eoc = 1'b0;
  logic [DW-1:0]        adc_data = '0;
  logic [NREQ-1:0]      gnt, done;
  logic [CH_W-1:0]      ch_sel;
  logic                 soc, timeout, busy;
  logic [DW-1:0]        rdata;

  adc_conv_arbiter #(.NREQ(NREQ), .CH_W(CH_W), .DW(DW), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .en(en), .prio_mode(prio_mode), .req(req),
    .req_ch(req_ch), .settle(settle), .gap(gap), .timeout_limit(timeout_limit),
    .gnt(gnt), .ch_sel(ch_sel), .soc(soc), .eoc(eoc), .adc_data(adc_data),
    .done(done), .rdata(rdata), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- ADC core emulation (sole driver of eoc/adc_data) -------
  int            adc_mode = 0;      // 0 = responsive core, 1 = silent, 2 = manual
  int            adc_dmin = 3, adc_dmax = 8;
  bit            adc_use_fixed = 1'b0;
  logic [DW-1:0] adc_fixed = '0;
  logic          man_eoc = 1'b0;
  logic [DW-1:0] man_data = '0;
  int            a_st = 0, a_cnt = 0;

  always @(negedge clk) begin
    if (adc_mode == 2) begin
      eoc = man_eoc; adc_data = man_data; a_st = 0;
    end else if (adc_mode == 1) begin
      eoc = 1'b0; a_st = 0;
    end else begin
      case (a_st)
        0: begin
          eoc = 1'b0;
          if (soc) begin a_cnt = $urandom_range(adc_dmax, adc_dmin); a_st = 1; end
        end
        1: begin
          a_cnt--;
          if (!soc) a_st = 0;
          else if (a_cnt <= 0) begin
            eoc = 1'b1;
            adc_data = adc_use_fixed ? adc_fixed : DW'($urandom);
            a_cnt = $urandom_range(3, 1);
            a_st = 2;
          end
        end
        2: begin
          a_cnt--;
          if (a_cnt <= 0) begin eoc = 1'b0; a_st = 3; end
        end
        default: if (!soc) a_st = 0;
      endcase
    end
  end

  // ---------------- behavioural model --------------------------------------
  // Each transaction is described by timestamps (cycle numbers): first CONV
  // cycle, the cycle of the done/timeout pulse, when gnt drops and when the
  // arbiter is idle again. Outputs for the coming cycle follow from these.
  longint        cyc = 0;
  bit            m_active = 1'b0, m_end_done = 1'b0, m_prev_eoc = 1'b0;
  longint        t_conv = 0, m_end = -1, m_idle_at = BIG, m_gnt_off = BIG;
  int            m_win = 0, m_ptr = NREQ - 1;
  logic [CH_W-1:0] m_ch = '0;
  logic [DW-1:0]   m_rdata = '0;
  logic [NREQ-1:0] exp_gnt = '0, exp_done = '0;
  logic [CH_W-1:0] exp_ch = '0;
  logic            exp_soc = 1'b0, exp_to = 1'b0, exp_busy = 1'b0;
  logic [DW-1:0]   exp_rdata = '0;

  function automatic int pick(input logic [NREQ-1:0] r, input bit pm, input int p);
    if (pm) begin
      for (int i = 0; i < NREQ; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic longint hold_len(input logic [7:0] g);
    return (g == 8'd0) ? 1 : longint'(g);
  endfunction

  always @(posedge clk or posedge rst) begin
    longint n, m;
    if (rst) begin
      m_active = 1'b0; m_prev_eoc = 1'b0; m_ptr = NREQ - 1;
      m_ch = '0; m_rdata = '0; m_end = -1;
      exp_gnt = '0; exp_done = '0; exp_ch = '0; exp_soc = 1'b0;
      exp_to = 1'b0; exp_busy = 1'b0; exp_rdata = '0;
    end else begin
      n = cyc;
      cyc++;
      if (!m_active) begin
        if (en && (req != '0)) begin
          m_win = pick(req, prio_mode, m_ptr);
          m_ptr = m_win;
          m_ch = req_ch[m_win*CH_W +: CH_W];
          m_active = 1'b1;
          t_conv = n + 1 + longint'(settle) + 1;
          m_end = -1; m_idle_at = BIG; m_gnt_off = BIG;
        end
      end else begin
        if (m_end < 0) begin
          if (n >= t_conv) begin
            if (eoc && !m_prev_eoc) begin
              m_end = n + 1; m_end_done = 1'b1; m_rdata = adc_data; m_gnt_off = n + 2;
            end else if (timeout_limit != '0 && (n - t_conv + 1) == longint'(timeout_limit)) begin
              m_end = n + 1; m_end_done = 1'b0; m_gnt_off = n + 1;
              m_idle_at = n + 1 + hold_len(gap);
            end
          end
        end else if (m_end_done && n == m_end) begin
          m_idle_at = n + 1 + hold_len(gap);
        end
        if (m_idle_at == n + 1) m_active = 1'b0;
      end
      m_prev_eoc = eoc;
      m = n + 1;
      exp_busy  = m_active;
      exp_gnt   = (m_active && m < m_gnt_off) ? NREQ'(1) << m_win : '0;
      exp_soc   = m_active && (m_end < 0) && (m >= t_conv + 1);
      exp_done  = (m_active && m == m_end && m_end_done) ? NREQ'(1) << m_win : '0;
      exp_to    = m_active && m == m_end && !m_end_done;
      exp_ch    = m_ch;
      exp_rdata = m_rdata;
    end
  end

  // ---------------- passive monitor ----------------------------------------
  int n_done = 0, n_to = 0;
  int gq[$];
  logic [NREQ-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (gnt != '0 && prev_gnt == '0) begin
      for (int i = 0; i < NREQ; i++) if (gnt[i]) gq.push_back(i);
    end
    if (done != '0) n_done++;
    if (timeout) n_to++;
    prev_gnt = gnt;
  end

  // ---------------- helpers ------------------------------------------------
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_soc(input string nm, input int budget);
    int k = 0;
    while (!soc && k < budget) begin @(negedge clk); k++; end
    check({nm, "_soc_seen"}, soc, 1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (done == '0 && k < budget) begin @(negedge clk); k++; end
    check({nm, "_done_seen"}, done != '0, 1);
  endtask

  task automatic wait_grant(input string nm, input int budget);
    int k = 0;
    while (gnt == '0 && k < budget) begin @(negedge clk); k++; end
    check({nm, "_gnt_seen"}, gnt != '0, 1);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin @(negedge clk); k++; end
    check({nm, "_idle_seen"}, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus and per-cycle comparison ----------------------
  initial begin
    int k, cnt, d0, t0, q0;

    fork
      forever begin
        @(negedge clk);
        check("gnt",     gnt,     exp_gnt);
        check("ch_sel",  ch_sel,  exp_ch);
        check("soc",     soc,     exp_soc);
        check("done",    done,    exp_done);
        check("rdata",   rdata,   exp_rdata);
        check("timeout", timeout, exp_to);
        check("busy",    busy,    exp_busy);
      end
    join_none

    tick(3);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    check("rst_soc", soc, 0);
    rst = 1'b0;
    tick(2);

    // Single requester, fixed 20-cycle conversion.
    req_ch = '0; req_ch[2:0] = 3'd5;
    settle = 4'd2; gap = 8'd3; timeout_limit = '0;
    adc_dmin = 20; adc_dmax = 20; adc_use_fixed = 1'b1; adc_fixed = 10'h2A5;
    en = 1'b1;
    req = 4'b0001;
    k = 0;
    while (!soc && k < 50) begin tick(1); k++; end
    check("t1_req_to_soc", k, 5);
    check("t1_ch_sel", ch_sel, 5);
    wait_done("t1", 40);
    req = '0;
    check("t1_done", done, 4'b0001);
    check("t1_rdata", rdata, 10'h2A5);
    check("t1_soc_low_in_done", soc, 0);
    tick(1);
    check("t1_done_width", done, 0);
    cnt = 2; k = 0;
    while (k < 20) begin
      tick(1); k++;
      if (!busy) break;
      if (!soc) cnt++;
    end
    check("t1_soc_low_cycles", cnt, 4);

    // Round-robin from a fresh pointer.
    rst = 1'b1; tick(2); rst = 1'b0;
    adc_dmin = 3; adc_dmax = 8; adc_use_fixed = 1'b0;
    req_ch = 12'o7531;
    prio_mode = 1'b0;
    q0 = gq.size();
    req = 4'b1111;
    k = 0;
    while (gq.size() < q0 + 5 && k < 2000) begin tick(1); k++; end
    req = '0;
    check("rr_grants", gq.size() >= q0 + 5, 1);
    for (int i = 0; i < 5; i++) begin
      if (gq.size() > q0 + i) check("rr_order", gq[q0+i], i % 4);
    end
    wait_idle("rr", 200);

    // Fixed priority: index 1 always beats index 3.
    prio_mode = 1'b1; adc_use_fixed = 1'b1; adc_fixed = 10'h133;
    q0 = gq.size();
    req = 4'b1010;
    k = 0;
    while (gq.size() < q0 + 4 && k < 2000) begin tick(1); k++; end
    req = '0;
    check("fp_grants", gq.size() >= q0 + 4, 1);
    for (int i = 0; i < 4; i++) begin
      if (gq.size() > q0 + i) check("fp_winner", gq[q0+i], 1);
    end
    wait_idle("fp", 200);

    // Timeout with a silent core.
    prio_mode = 1'b0; timeout_limit = 12'd16; adc_mode = 1;
    d0 = n_done; t0 = n_to;
    req = 4'b0001;
    wait_grant("to", 10);
    req = '0;
    wait_soc("to", 20);
    k = 0;
    while (!timeout && k < 40) begin tick(1); k++; end
    check("to_pulse_delay", k, 15);
    wait_idle("to", 50);
    check("to_no_done", n_done - d0, 0);
    check("to_pulses", n_to - t0, 1);
    check("to_rdata_kept", rdata, 10'h133);
    adc_mode = 0; timeout_limit = '0;
    req = 4'b0100;
    wait_done("to_resume", 60);
    check("to_resume_done", done, 4'b0100);
    req = '0;
    wait_idle("to_resume", 50);

    // EoC already high on CONV entry: only the later rise captures.
    adc_mode = 2; man_eoc = 1'b1; man_data = 10'h0F0;
    d0 = n_done;
    req = 4'b0001;
    wait_soc("lvl", 30);
    req = '0;
    tick(4);
    check("lvl_no_early_done", n_done - d0, 0);
    man_eoc = 1'b0; tick(2);
    man_data = 10'h155; man_eoc = 1'b1;
    wait_done("lvl", 10);
    check("lvl_rdata", rdata, 10'h155);
    man_eoc = 1'b0;
    wait_idle("lvl", 50);

    // Edge and limit match in the same cycle.
    timeout_limit = 12'd8;
    d0 = n_done; t0 = n_to;
    req = 4'b0010;
    wait_soc("race", 30);
    req = '0;
    tick(6);
    man_data = 10'h3C3; man_eoc = 1'b1;
    wait_idle("race", 50);
    check("race_done", n_done - d0, 1);
    check("race_no_timeout", n_to - t0, 0);
    check("race_rdata", rdata, 10'h3C3);
    man_eoc = 1'b0; timeout_limit = '0; adc_mode = 0;
    tick(2);

    // Request dropped mid-conversion.
    adc_dmin = 10; adc_dmax = 10;
    req = 4'b1000;
    wait_soc("drop", 30);
    req = '0;
    wait_done("drop", 40);
    check("drop_done", done, 4'b1000);
    wait_idle("drop", 50);

    // Asynchronous reset during CONV.
    adc_dmin = 30; adc_dmax = 30;
    req = 4'b0001;
    wait_soc("arst", 30);
    #2 rst = 1'b1;
    #1;
    check("arst_soc", soc, 0);
    check("arst_gnt", gnt, 0);
    check("arst_busy", busy, 0);
    check("arst_ch_sel", ch_sel, 0);
    check("arst_rdata", rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_grant("arst", 5);
    check("arst_regrant", gnt, 4'b0001);
    req = '0;
    wait_idle("arst", 100);

    // Enable low blocks new grants.
    en = 1'b0;
    req = 4'b0110;
    tick(10);
    check("en_no_gnt", gnt, 0);
    check("en_no_busy", busy, 0);
    en = 1'b1;
    adc_dmin = 3; adc_dmax = 8;
    wait_grant("en", 5);
    check("en_gnt", gnt, 4'b0010);
    req = '0;
    wait_idle("en", 100);

    // Randomized operation.
    adc_use_fixed = 1'b0; adc_dmin = 1; adc_dmax = 45;
    for (int it = 0; it < 300; it++) begin
      prio_mode     = 1'($urandom);
      settle        = 4'($urandom_range(3, 0));
      gap           = 8'($urandom_range(4, 0));
      timeout_limit = ($urandom_range(2, 0) == 0) ? '0 : TO_W'($urandom_range(40, 5));
      req           = NREQ'($urandom);
      req_ch        = (NREQ*CH_W)'($urandom);
      en            = ($urandom_range(7, 0) != 0);
      tick($urandom_range(12, 1));
    end
    req = '0; en = 1'b1;
    wait_idle("rand", 500);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_conv_arbiter.md
Name: adc_conv_arbiter

Overview:
- Shares one SAR ADC core (SoC/EoC/channel-select/data interface) among NREQ requesters.
- Arbitrates pending requests, drives the channel mux and waits a settle time.
- Issues a level SoC, captures the result on the rising edge of EoC, and returns it to the winning requester with a one-cycle done pulse.
- Sits between requester logic (timers, software, DMA) and the ADC core; includes a conversion timeout.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CH_W, 3, channel select width
- DW, 10, conversion data width
- TO_W, 12, timeout counter width

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  asynchronous active-high reset
- en  in  1  arbiter enable; gates new grants only
- prio_mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest)
- req  in  NREQ  level request per requester
- req_ch  in  NREQ*CH_W  channel per requester; slice i is requester i
- settle  in  4  mux settle time in clk cycles
- gap  in  8  minimum SoC-low cycles between conversions
- timeout_limit  in  TO_W  max clk cycles waiting for EoC; 0 disables the timeout
- gnt  out  NREQ  one-hot grant, held from grant until done/timeout
- ch_sel  out  CH_W  channel to the ADC mux
- soc  out  1  level start-of-conversion to the ADC core
- eoc  in  1  end of conversion from the ADC core; multi-cycle level
- adc_data  in  DW  ADC result, valid while eoc is high
- done  out  NREQ  one-cycle pulse on the granted bit when the result is valid
- rdata  out  DW  last captured result, held until the next capture
- timeout  out  1  one-cycle pulse when a conversion times out
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, and also mid-operation): state = IDLE; gnt, done, soc, timeout, busy = 0; ch_sel = 0; rdata = 0; RR pointer = NREQ-1; eoc edge register = 0.
- IDLE:
  - If en and any req bit is high, select a winner.
  - Register gnt (one-hot) and ch_sel = req_ch[winner], load the settle counter, go to SETTLE.
  - gnt is high the cycle after the request is seen.
- Winner selection:
  - prio_mode = 1: lowest asserted index.
  - prio_mode = 0: first asserted index searching upward from pointer+1, wrapping modulo NREQ.
  - The pointer updates to the winner at grant time only.
- SETTLE: lasts settle+1 cycles (settle = 0 gives 1 cycle), then go to CONV.
- CONV:
  - soc = 1; the timeout counter increments every cycle.
  - On the eoc rising edge (eoc = 1 with the registered eoc = 0): rdata <= adc_data, go to DONE.
  - If timeout_limit != 0 and the counter equals timeout_limit with no edge: pulse timeout for one cycle, leave rdata unchanged, go to HOLD (no done).
  - If the eoc edge and the limit match occur in the same cycle, the edge wins.
  - An eoc level already high on entry to CONV is not an edge.
- DONE: one cycle. done[winner] = 1, soc = 0, gnt cleared at the end of the cycle, go to HOLD.
- HOLD:
  - soc = 0 for gap cycles (gap = 0 gives 1 cycle minimum), then go to IDLE.
  - Guarantees the core's SoC edge detector sees the low level.
- Latency: request-to-soc = settle+3 cycles. done occurs 1 cycle after the eoc rising edge.
- req deassertion after grant does not abort: the conversion completes and done still pulses.
- A requester must drop req in the cycle after done, or it is re-arbitrated normally.
- en low blocks only new grants; an in-flight conversion finishes.
- req_ch changes after grant are ignored; ch_sel is stable from grant to the end of HOLD.
- busy = (state != IDLE). gnt, soc, done and timeout are registered outputs, glitch-free.

Test Plan:
- Single requester: req = 0001, req_ch[0] = 5, settle = 2, gap = 3; eoc rises 20 cycles after soc with adc_data = 0x2A5. Required: ch_sel = 5, soc high 5 cycles after req, done = 0001 for one cycle, rdata = 0x2A5, soc low ≥ 3 cycles before IDLE.
- Round-robin: req = 1111 held, prio_mode = 0. Required: grant order 0,1,2,3,0, each done pulse matching gnt.
- Fixed priority: req = 1010 held, prio_mode = 1. Required: every grant goes to index 1; index 3 is never granted.
- Timeout: timeout_limit = 16, eoc held 0. Required: timeout pulses once 16 cycles into CONV, no done, rdata unchanged, then arbitration resumes.
- Edge cases:
  - eoc already high on CONV entry, then low, then high: capture only on the second rise.
  - Edge and limit match in the same cycle: done asserts and timeout does not.
  - req dropped mid-CONV: done still pulses.
- Reset and enable:
  - Assert rst during CONV: all outputs 0 immediately (asynchronous); after release, a pending req is granted normally.
  - en = 0 with req pending: no grant.
